// File: rtl/frame_parity_checker_if.sv
// rtl/frame_parity_checker_if.sv - beat handshake bundle for frame_parity_checker
// Ports: in_valid/in_data from the upstream deserialiser, in_ready back to it.
// master = beat source, slave = frame_parity_checker.
interface frame_parity_checker_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/frame_parity_checker.sv
// rtl/frame_parity_checker.sv - running XOR parity checker over fixed-length frames
// Ports: clk, reset (sync, active-high), clear (sync frame abort),
//        beat (slave handshake: in_valid, in_data, in_ready),
//        run_parity, frame_done, parity_err, err_count (only with PARITY_ERR_CNT_EN).
// Optional macro PARITY_ERR_CNT_EN adds a saturating frame-error counter.
module frame_parity_checker #(
  parameter int WIDTH       = 8,
  parameter int FRAME_BEATS = 4,
  parameter int ODD         = 0,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  frame_parity_checker_if.slave beat,
  output logic                  run_parity,
  output logic                  frame_done,
  output logic                  parity_err
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]      err_count
`endif
);

  localparam int          CB      = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [CB-1:0] LAST  = CB'(FRAME_BEATS - 1);
  localparam logic        ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t           state;
  logic [CB-1:0]    cnt;
  logic             ready_q;
  logic [WIDTH-1:0] data;
  logic             xfer;
  logic             mismatch;

  assign data          = beat.in_data;
  assign beat.in_ready = ready_q;
  assign xfer          = beat.in_valid && ready_q;
  // Parity bit of the check beat disagrees with the accumulated frame parity.
  assign mismatch      = data[0] ^ run_parity ^ ODD_BIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      run_parity <= 1'b0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      ready_q    <= 1'b1;
    end else if (clear) begin
      // Any beat presented alongside clear is swallowed with the aborted frame.
      state      <= IDLE;
      cnt        <= '0;
      run_parity <= 1'b0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state)
        IDLE, DATA: begin
          frame_done <= 1'b0;
          parity_err <= 1'b0;
          if (xfer) begin
            run_parity <= run_parity ^ (^data);
            if (cnt == LAST) begin
              // Counter parks on the last index until REPORT clears it.
              state <= CHECK;
            end else begin
              cnt   <= cnt + CB'(1);
              state <= DATA;
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            parity_err <= mismatch;
            frame_done <= 1'b1;
            ready_q    <= 1'b0;
            state      <= REPORT;
          end
        end
        REPORT: begin
          state      <= IDLE;
          cnt        <= '0;
          run_parity <= 1'b0;
          frame_done <= 1'b0;
          parity_err <= 1'b0;
          ready_q    <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          run_parity <= 1'b0;
          frame_done <= 1'b0;
          parity_err <= 1'b0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Survives clear; only reset zeroes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (!clear && state == CHECK && xfer && mismatch &&
                 err_count != {CNT_W{1'b1}}) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_frame_parity_checker.sv
// tb/tb_frame_parity_checker.sv - scoreboard bench for frame_parity_checker
module tb_frame_parity_checker;

  localparam int W     = 8;
  localparam int A_FB  = 4;
  localparam int A_ODD = 0;
  localparam int B_FB  = 1;
  localparam int B_ODD = 1;
  localparam int CNT_W = 2;

  logic clk;
  logic reset;
  logic a_clear, b_clear;
  logic a_run_parity, a_frame_done, a_parity_err;
  logic b_run_parity, b_frame_done, b_parity_err;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] a_err_count, b_err_count;
`endif

  frame_parity_checker_if #(.WIDTH(W)) a_if ();
  frame_parity_checker_if #(.WIDTH(W)) b_if ();

  frame_parity_checker #(.WIDTH(W), .FRAME_BEATS(A_FB), .ODD(A_ODD), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset(reset), .clear(a_clear), .beat(a_if.slave),
    .run_parity(a_run_parity), .frame_done(a_frame_done), .parity_err(a_parity_err)
`ifdef PARITY_ERR_CNT_EN
    , .err_count(a_err_count)
`endif
  );

  frame_parity_checker #(.WIDTH(W), .FRAME_BEATS(B_FB), .ODD(B_ODD), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear), .beat(b_if.slave),
    .run_parity(b_run_parity), .frame_done(b_frame_done), .parity_err(b_parity_err)
`ifdef PARITY_ERR_CNT_EN
    , .err_count(b_err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];
  logic exp_run;
  int   model_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every frame_done pops one expected result from the scoreboard.
  always @(negedge clk) begin
    logic e;
    if (!reset) begin
      if (a_frame_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("parity_err", {31'd0, a_parity_err}, {31'd0, e});
          chk("in_ready_in_report", {31'd0, a_if.in_ready}, 32'd0);
`ifdef PARITY_ERR_CNT_EN
          if (e && model_cnt < (1 << CNT_W) - 1) model_cnt++;
          chk("err_count", {30'd0, a_err_count}, model_cnt);
`endif
        end
      end else begin
        chk("parity_err_idle", {31'd0, a_parity_err}, 32'd0);
      end
    end
  end

  task automatic a_beat(input logic [7:0] d, input int gap);
    int n;
    a_if.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    n = 0;
    while (!a_if.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int gm);
    return (gm < 0) ? int'($urandom_range(0, 2)) : gm;
  endfunction

  // Model: frame error is parity bit vs. XOR of every data bit in the frame, flipped for ODD.
  task automatic a_frame(input logic [31:0] beats, input logic [7:0] par, input int gm);
    logic [7:0] b;
    for (int i = 0; i < A_FB; i++) begin
      b = beats[8*i +: 8];
      a_beat(b, pick_gap(gm));
      exp_run = exp_run ^ (^b);
      chk("run_parity", {31'd0, a_run_parity}, {31'd0, exp_run});
    end
    exp_q.push_back(par[0] ^ (^beats) ^ 1'(A_ODD));
    a_beat(par, pick_gap(gm));
    exp_run = 1'b0;
  endtask

  task automatic a_abort(input logic [31:0] beats, input int k);
    for (int i = 0; i < k; i++) a_beat(beats[8*i +: 8], 0);
    a_clear       = 1'b1;
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'($urandom);
    @(posedge clk); #1;
    a_clear       = 1'b0;
    a_if.in_valid = 1'b0;
    exp_run       = 1'b0;
    chk("clear_run_parity", {31'd0, a_run_parity}, 32'd0);
    chk("clear_frame_done", {31'd0, a_frame_done}, 32'd0);
    chk("clear_in_ready", {31'd0, a_if.in_ready}, 32'd1);
  endtask

  task automatic b_frame(input logic [7:0] d, input logic [7:0] par);
    b_if.in_valid = 1'b1;
    b_if.in_data  = d;
    @(posedge clk); #1;
    chk("b_run_parity", {31'd0, b_run_parity}, {31'd0, ^d});
    chk("b_done_early", {31'd0, b_frame_done}, 32'd0);
    b_if.in_data = par;
    @(posedge clk); #1;
    chk("b_frame_done", {31'd0, b_frame_done}, 32'd1);
    chk("b_parity_err", {31'd0, b_parity_err}, {31'd0, par[0] ^ (^d) ^ 1'(B_ODD)});
    chk("b_in_ready_report", {31'd0, b_if.in_ready}, 32'd0);
    b_if.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_done_cleared", {31'd0, b_frame_done}, 32'd0);
    chk("b_err_cleared", {31'd0, b_parity_err}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; a_clear = 1'b0; b_clear = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0;
    exp_run = 1'b0; model_cnt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", {31'd0, a_if.in_ready}, 32'd1);
    chk("rst_run_parity", {31'd0, a_run_parity}, 32'd0);
    chk("rst_frame_done", {31'd0, a_frame_done}, 32'd0);
    chk("rst_parity_err", {31'd0, a_parity_err}, 32'd0);
`ifdef PARITY_ERR_CNT_EN
    chk("rst_err_count", {30'd0, a_err_count}, 32'd0);
    chk("rst_b_err_count", {30'd0, b_err_count}, 32'd0);
`endif

    // Directed frames: good, bad, gapped, bad x5 for counter saturation.
    a_frame(32'hFF00_0301, 8'h01, 0);
    a_frame(32'hFF00_0301, 8'h00, 0);
    a_frame(32'hFF00_0301, 8'h01, 1);
    for (int i = 0; i < 5; i++) a_frame(32'hFF00_0301, 8'h00, 0);
    a_abort(32'hFF00_0301, 2);
    a_frame(32'hFF00_0301, 8'h01, 0);

    // Reset together with clear and a valid beat, mid-frame.
    a_beat(8'h01, 0);
    a_beat(8'h07, 0);
    reset = 1'b1; a_clear = 1'b1; a_if.in_valid = 1'b1; a_if.in_data = 8'hFF;
    @(posedge clk); #1;
    reset = 1'b0; a_clear = 1'b0; a_if.in_valid = 1'b0;
    exp_run = 1'b0; model_cnt = 0;
    chk("rst2_in_ready", {31'd0, a_if.in_ready}, 32'd1);
    chk("rst2_run_parity", {31'd0, a_run_parity}, 32'd0);
    chk("rst2_frame_done", {31'd0, a_frame_done}, 32'd0);
    chk("rst2_parity_err", {31'd0, a_parity_err}, 32'd0);
`ifdef PARITY_ERR_CNT_EN
    chk("rst2_err_count", {30'd0, a_err_count}, 32'd0);
`endif

    // Single-beat, odd-parity instance; upper bits of parity beat ignored.
    b_frame(8'h00, 8'h01);
    b_frame(8'h00, 8'hFE);
    b_frame(8'h5A, 8'hFF);
    b_frame(8'h01, 8'h00);

    // Randomised frames with occasional aborts at any point.
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 9) == 0) a_abort($urandom, $urandom_range(0, A_FB));
      else a_frame($urandom, 8'($urandom), -1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin @(posedge clk); n++; end
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_parity_checker.md
Name: frame_parity_checker

Overview:
- Parametrised successor of the single-bit Moore parity checker.
- Accepts WIDTH-bit beats over a valid/ready handshake and accumulates the running XOR parity of a frame of FRAME_BEATS data beats.
- Checks the result against a trailing parity beat and reports a one-cycle frame result.
- Sits between a serial/deserialiser front end and the link-error logic; all outputs are registered state (Moore).

Parameters:
- WIDTH, 8, data bits per beat (>=1).
- FRAME_BEATS, 4, data beats per frame, excluding the parity beat (>=1).
- ODD, 0, 0 = even parity expected, 1 = odd parity expected.
- CNT_W, 8, error-counter width; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous frame abort.
- in_valid  in  1  beat valid.
- in_data  in  WIDTH  beat payload; bit 0 carries the expected parity on the parity beat.
- in_ready  out  1  block can accept a beat.
- run_parity  out  1  XOR of all data bits accepted so far in the current frame.
- frame_done  out  1  one-cycle pulse, frame result valid.
- parity_err  out  1  frame parity mismatch; meaningful only while frame_done=1, otherwise 0.
- err_count  out  CNT_W  saturating error count (present only with PARITY_ERR_CNT_EN).

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and reset.
- Reset values:
  - state=IDLE, beat counter=0, run_parity=0, frame_done=0, parity_err=0, err_count=0.
  - in_ready=1 in the first cycle after reset.
- Beat transfer occurs on a rising edge with in_valid && in_ready. in_valid while in_ready=0 is not a transfer; upstream holds the beat.
- in_ready = 1 in IDLE, DATA and CHECK; 0 in REPORT. It is decoded from registered state only, with no combinational path from in_valid.
- States:
  - IDLE: no beat accepted in the current frame.
  - DATA: collecting data beats.
  - CHECK: waiting for the parity beat.
  - REPORT: result cycle.
- IDLE or DATA, on transfer:
  - run_parity <= run_parity ^ (XOR-reduce in_data); counter++.
  - If this was beat FRAME_BEATS-1 (counting from 0), go to CHECK; else go to DATA.
  - With FRAME_BEATS=1 the path is IDLE -> CHECK directly.
- CHECK, on transfer:
  - expected = run_parity ^ ODD.
  - parity_err <= (in_data[0] != expected). in_data[WIDTH-1:1] is ignored.
  - Go to REPORT.
- REPORT (exactly 1 cycle):
  - frame_done=1, parity_err holds the result.
  - Next state is IDLE; run_parity and the counter are cleared on that same edge.
  - frame_done and parity_err return to 0 in IDLE.
- No transfer: state, counter and run_parity hold.
- Counter width is clog2(FRAME_BEATS), minimum 1; it never exceeds FRAME_BEATS-1.
- clear=1 (in any state, including REPORT):
  - Next state IDLE; run_parity, counter, frame_done and parity_err are cleared.
  - A beat presented in the same cycle is consumed and discarded.
  - No frame_done pulse is emitted for the aborted frame.
- reset has priority over clear. Reset mid-frame discards the partial frame identically to clear.
- Back-to-back frames: minimum frame period is FRAME_BEATS+2 cycles (data beats, parity beat, REPORT).

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined:
  - Port err_count[CNT_W-1:0] exists.
  - Increments by 1 on the edge entering REPORT with a mismatch.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; clear does not affect it.
- Undefined: err_count port and counter logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, FRAME_BEATS=4, ODD=0; beats 0x01, 0x03, 0x00, 0xFF, then parity beat 0x01 -> run_parity=1 after beat 4; frame_done=1 with parity_err=0 on the cycle after the parity beat; in_ready=0 that cycle.
- Same data, parity beat 0x00 -> frame_done=1, parity_err=1; err_count goes 0->1 when the feature is enabled.
- ODD=1, beats 0x00 x4, parity beat 0x01 -> parity_err=0; parity beat 0xFE (bit0=0) -> parity_err=1, confirming bits 7:1 are ignored.
- in_valid toggled 1,0,1,0 across the frame -> only valid cycles advance the counter; result matches the gap-free run; in_valid held high during REPORT is not consumed.
- clear asserted after 2 data beats, then a full good frame -> no frame_done for the aborted frame; next frame reports parity_err=0. Reset asserted simultaneously with clear and a valid beat -> all outputs at reset values next cycle.
- CNT_W=2 with PARITY_ERR_CNT_EN, 5 consecutive bad frames -> err_count 1, 2, 3, 3, 3. FRAME_BEATS=1 -> IDLE -> CHECK -> REPORT, with frame_done 2 cycles after the first beat.
